// File: rtl/viterbi_dec.sv
// Hard-decision register-exchange Viterbi decoder for the K=7, rate-1/2 (133,171) code.
// Decisions come from the state-0 survivor; a flush drains the pending survivor bits.
module viterbi_dec #(
    parameter int TB_DEPTH = 48,
    parameter int PM_W     = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       dec_en,
    input  logic [1:0] bits_in,
    input  logic [1:0] erase,
    input  logic       flush,
    output logic       bit_out,
    output logic       bit_out_valid,
    output logic       busy,
    output logic       done
);

    localparam int D  = TB_DEPTH;
    localparam int NS = 64;
    localparam int CW = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [D-1:0]      drain_q, drain_d;
    logic [PM_W-1:0]   pm_q [NS];
    logic [PM_W-1:0]   pm_d [NS];
    logic [PM_W-1:0]   pm_acs [NS];
    logic [D-1:0]      surv_q [NS];
    logic [D-1:0]      surv_d [NS];
    logic [D-1:0]      surv_acs [NS];
    logic              bit_out_q, bit_out_d;
    logic              bit_out_valid_q, bit_out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              reinit;
    logic [D-1:0]      flush_src;
    logic [CW-1:0]     pending;

    function automatic logic [1:0] branch_metric(
        input logic [5:0] s,
        input logic       b,
        input logic [1:0] rx,
        input logic [1:0] er
    );
        logic e0;
        logic e1;
        e0 = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
        e1 = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
        return {1'b0, ~er[0] & (rx[0] ^ e0)} + {1'b0, ~er[1] & (rx[1] ^ e1)};
    endfunction

    // State 0 starts ahead so that the decoder assumes the encoder began zeroed.
    function automatic logic [PM_W-1:0] init_pm(input int idx);
        return (idx == 0) ? '0 : PM_W'(32);
    endfunction

    for (genvar n = 0; n < NS; n++) begin : g_acs
        localparam logic [5:0] P0 = 6'(n / 2);
        localparam logic [5:0] P1 = 6'(n / 2 + 32);
        localparam logic       B  = 1'(n % 2);

        logic [1:0]      bm0;
        logic [1:0]      bm1;
        logic [PM_W-1:0] cand0;
        logic [PM_W-1:0] cand1;
        logic [PM_W-1:0] diff;
        logic            sel1;

        assign bm0   = branch_metric(P0, B, bits_in, erase);
        assign bm1   = branch_metric(P1, B, bits_in, erase);
        assign cand0 = pm_q[P0] + PM_W'(bm0);
        assign cand1 = pm_q[P1] + PM_W'(bm1);
        // Modular compare: p1 wins only when strictly smaller; ties keep p0.
        assign diff  = cand0 - cand1;
        assign sel1  = ~diff[PM_W-1] && (diff != '0);

        assign pm_acs[n]   = sel1 ? cand1 : cand0;
        assign surv_acs[n] = sel1 ? {surv_q[P1][D-2:0], B} : {surv_q[P0][D-2:0], B};
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        drain_d         = drain_q;
        drain_cnt_d     = drain_cnt_q;
        pm_d            = pm_q;
        surv_d          = surv_q;
        bit_out_d       = 1'b0;
        bit_out_valid_d = 1'b0;
        done_d          = 1'b0;
        reinit          = 1'b0;
        flush_src       = surv_q[0];
        pending         = '0;

        unique case (state_q)
            IDLE: begin
                if (dec_en) begin
                    pm_d    = pm_acs;
                    surv_d  = surv_acs;
                    cnt_d   = CW'(1);
                    state_d = FILL;
                end
            end
            FILL, RUN: begin
                if (dec_en) begin
                    pm_d      = pm_acs;
                    surv_d    = surv_acs;
                    flush_src = surv_acs[0];
                    if (state_q == RUN) begin
                        bit_out_d       = surv_acs[0][D-1];
                        bit_out_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CW'(D)) begin
                            state_d         = RUN;
                            bit_out_d       = surv_acs[0][D-1];
                            bit_out_valid_d = 1'b1;
                        end
                    end
                end
                // Pending bits are left-aligned so the drain always shifts out of the MSB.
                if (flush) begin
                    pending = (state_d == RUN) ? CW'(D - 1) : cnt_d;
                    if (pending == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        reinit  = 1'b1;
                    end else begin
                        drain_d     = flush_src << (CW'(D) - pending);
                        drain_cnt_d = pending;
                        state_d     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                bit_out_d       = drain_q[D-1];
                bit_out_valid_d = 1'b1;
                drain_d         = drain_q << 1;
                drain_cnt_d     = drain_cnt_q - CW'(1);
                if (drain_cnt_q == CW'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    reinit  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reinit) begin
            cnt_d = '0;
            for (int i = 0; i < NS; i++) begin
                pm_d[i]   = init_pm(i);
                surv_d[i] = '0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            drain_q         <= '0;
            drain_cnt_q     <= '0;
            bit_out_q       <= 1'b0;
            bit_out_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                pm_q[i]   <= init_pm(i);
                surv_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            drain_q         <= drain_d;
            drain_cnt_q     <= drain_cnt_d;
            bit_out_q       <= bit_out_d;
            bit_out_valid_q <= bit_out_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            for (int i = 0; i < NS; i++) begin
                pm_q[i]   <= pm_d[i];
                surv_q[i] <= surv_d[i];
            end
        end
    end

    assign bit_out       = bit_out_q;
    assign bit_out_valid = bit_out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
